rcc_eth_clk_sel_seq: RTL and testbench
======================================

// Module: rcc_eth_clk_sel_seq
// PURPOSE
// - Sequencer that drives eth_rcc_fes / eth_rcc_epis_2 into the ETH kernel clock controller.
// - On a speed or interface change it gates the ETH clocks, applies the new select values, and waits for the
//   glitch-free switch to settle on the RX pad clock. It then ungates the clocks and acknowledges the MAC.
// - Sits between the ETH MAC configuration logic and the RCC ETH kernel clock path. Runs on the RCC bus clock.
// PARAMETERS
// - GATE_CYC   default 4     cycles clk_gate_hold is held before and after the select update (>=1)
// - MIN_EDGES  default 3     RX pad-clock toggles required after the select update before the switch counts as settled
// - TIMEOUT    default 1024  cycles allowed in SETTLE without reaching MIN_EDGES; reaching it raises err
// PORTS
// - clk_in         in   1  RCC bus clock
// - rst_n          in   1  synchronous active-low reset
// - mac_req        in   1  change request; level, held until mac_ack
// - mac_fes        in   1  requested speed: 1 = 100M (div_2 path), 0 = 10M (div_20 path)
// - mac_epis       in   1  requested interface: 1 = RMII, 0 = MII
// - rx_clk_tog     in   1  toggle of pad_rcc_eth_mii_rx_clk, already synchronised into clk_in
// - eth_rcc_fes    out  1  speed select to the clock controller
// - eth_rcc_epis_2 out  1  interface select to the clock controller
// - clk_gate_hold  out  1  1 = force all ETH kernel clock gates off
// - busy           out  1  sequence in progress
// - mac_ack        out  1  one-cycle completion pulse
// - err            out  1  sticky settle timeout; cleared only by reset or by the next accepted request
// BEHAVIOUR
// - Single clock domain; every flop updates on the clk_in rising edge.
// - Reset (rst_n = 0 at an edge):
//   - eth_rcc_fes = 0, eth_rcc_epis_2 = 0, clk_gate_hold = 0, busy = 0, mac_ack = 0, err = 0, state IDLE.
//   - Reset applied in any state aborts immediately; the select outputs return to 0 and no ack is issued.
// - FSM states: IDLE, GATE_OFF, SETTLE, GATE_ON, ACK.
// - IDLE:
//   - mac_req = 1 and {mac_fes, mac_epis} == current outputs: go to ACK next cycle (no gating); err cleared.
//   - mac_req = 1 and the values differ: capture mac_fes/mac_epis, clear err, go to GATE_OFF.
//     clk_gate_hold and busy rise on the next cycle.
// - GATE_OFF:
//   - clk_gate_hold = 1 for GATE_CYC cycles.
//   - On the last cycle, load the captured values onto eth_rcc_fes / eth_rcc_epis_2 and go to SETTLE.
// - SETTLE:
//   - Count rx_clk_tog edges (any change versus the previous sample) and count cycles; hold stays 1.
//   - edge count == MIN_EDGES: go to GATE_ON.
//   - cycle count == TIMEOUT-1 without MIN_EDGES: set err = 1 and go to GATE_ON anyway, keeping the new
//     select values.
//   - An edge on the timeout cycle counts as settled; err is not set.
// - GATE_ON:
//   - clk_gate_hold stays 1 for GATE_CYC cycles, then drops to 0 on entry to ACK.
// - ACK:
//   - mac_ack = 1 for exactly one cycle; busy drops in the same cycle; return to IDLE.
// - mac_req is sampled only in IDLE.
//   - Changes of mac_fes/mac_epis while busy are ignored.
//   - mac_req still high in IDLE after an ack starts a new request; the MAC must drop req on ack.
// - Counters saturate and never wrap. Widths: $clog2(TIMEOUT), $clog2(GATE_CYC+1), $clog2(MIN_EDGES+1).
// - The select outputs never change while clk_gate_hold = 0.
// - Latency for a real change, from req sampled to ack: 2*GATE_CYC + settle cycles + 2.
// TESTING
// - Reset check: reset, then release -> all outputs 0 and state IDLE.
// - Normal change: req with fes=1, epis=0 while rx_clk_tog toggles every 2 cycles (defaults)
//   -> hold high for 4 cycles, eth_rcc_fes rises, 3 edges counted, hold low after 4 more cycles,
//      one-cycle ack, err = 0.
// - No-op request: req with fes=0, epis=0 from reset state -> ack 2 cycles later, clk_gate_hold never asserted.
// - Timeout: req with epis=1 and rx_clk_tog stuck -> err = 1 after 1024 cycles in SETTLE,
//   eth_rcc_epis_2 = 1, ack still issued.
//   - A following valid request clears err.
// - Reset mid-sequence: assert rst_n = 0 during SETTLE -> next cycle hold = 0, selects = 0, no ack.
// - Busy filtering: toggle mac_fes during GATE_ON -> outputs keep the captured value.
//   - Exactly one ack per accepted request.

Source files
------------

// File: rtl/rcc_eth_clk_sel_seq_if.sv
// MAC-side handshake between the ETH MAC configuration logic and the
// ETH kernel clock select sequencer.
interface rcc_eth_clk_sel_seq_if;
  logic mac_req;   // change request, level, held until mac_ack
  logic mac_fes;   // requested speed: 1 = 100M, 0 = 10M
  logic mac_epis;  // requested interface: 1 = RMII, 0 = MII
  logic mac_ack;   // one-cycle completion pulse
  logic busy;      // sequence in progress
  logic err;       // sticky settle timeout

  modport master (
    output mac_req, mac_fes, mac_epis,
    input  mac_ack, busy, err
  );

  modport slave (
    input  mac_req, mac_fes, mac_epis,
    output mac_ack, busy, err
  );
endinterface

// File: rtl/rcc_eth_clk_sel_seq.sv
// ETH kernel clock select sequencer.
// On a speed/interface change the ETH kernel clocks are gated, the new
// select values are applied, the RX pad clock is watched until the
// glitch-free switch has produced enough toggles, then the clocks are
// ungated and the MAC is acknowledged. A settle timeout still completes
// the sequence but leaves a sticky error flag.
module rcc_eth_clk_sel_seq #(
  parameter int GATE_CYC  = 4,
  parameter int MIN_EDGES = 3,
  parameter int TIMEOUT   = 1024
) (
  input  logic                 clk_in,
  input  logic                 rst_n,
  rcc_eth_clk_sel_seq_if.slave mac,
  input  logic                 rx_clk_tog,
  output logic                 eth_rcc_fes,
  output logic                 eth_rcc_epis_2,
  output logic                 clk_gate_hold
);

  localparam int CYC_W  = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam int GATE_W = $clog2(GATE_CYC + 1);
  localparam int EDGE_W = $clog2(MIN_EDGES + 1);

  localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYC - 1);
  localparam logic [CYC_W-1:0]  CYC_LAST  = CYC_W'(TIMEOUT - 1);
  localparam logic [EDGE_W-1:0] EDGE_TGT  = EDGE_W'(MIN_EDGES);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    GATE_OFF = 3'd1,
    SETTLE   = 3'd2,
    GATE_ON  = 3'd3,
    ACK      = 3'd4
  } state_t;

  state_t              state_q, state_d;
  logic [GATE_W-1:0]   gate_cnt_q, gate_cnt_d;
  logic [CYC_W-1:0]    cyc_cnt_q, cyc_cnt_d;
  logic [EDGE_W-1:0]   edge_cnt_q, edge_cnt_d;
  logic [EDGE_W-1:0]   edge_inc;

  logic                fes_cap_q, epis_cap_q;
  logic                fes_q, epis_q;
  logic                hold_q, busy_q, ack_q, err_q;
  logic                rx_tog_p0;

  logic                cap_load, sel_load, err_set, err_clr;
  logic                edge_seen, req_same, settled;

  // Gating is active in every state between accepting a change and the ack.
  function automatic logic gating(input state_t s);
    return (s == GATE_OFF) || (s == SETTLE) || (s == GATE_ON);
  endfunction

  assign edge_seen = rx_clk_tog ^ rx_tog_p0;
  assign req_same  = (mac.mac_fes == fes_q) && (mac.mac_epis == epis_q);
  // Edge counter saturates at the target so it can never wrap.
  assign edge_inc  = (edge_seen && (edge_cnt_q != EDGE_TGT)) ? edge_cnt_q + 1'b1 : edge_cnt_q;
  assign settled   = (edge_inc == EDGE_TGT);

  // Previous RX toggle sample for edge detection, plus request capture.
  always_ff @(posedge clk_in) begin
    rx_tog_p0 <= rx_clk_tog;
    if (cap_load) begin
      fes_cap_q  <= mac.mac_fes;
      epis_cap_q <= mac.mac_epis;
    end
  end

  // Next-state, counter and strobe decode for the sequencer.
  always_comb begin
    state_d    = state_q;
    gate_cnt_d = gate_cnt_q;
    cyc_cnt_d  = cyc_cnt_q;
    edge_cnt_d = edge_cnt_q;
    cap_load   = 1'b0;
    sel_load   = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    case (state_q)
      IDLE: begin
        gate_cnt_d = '0;
        cyc_cnt_d  = '0;
        edge_cnt_d = '0;
        if (mac.mac_req) begin
          err_clr = 1'b1;
          if (req_same) begin
            // Nothing to switch: acknowledge without touching the gates.
            state_d = ACK;
          end else begin
            cap_load = 1'b1;
            state_d  = GATE_OFF;
          end
        end
      end
      GATE_OFF: begin
        if (gate_cnt_q == GATE_LAST) begin
          // Clocks have been off long enough; switch selects under the gate.
          sel_load   = 1'b1;
          gate_cnt_d = '0;
          state_d    = SETTLE;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      SETTLE: begin
        edge_cnt_d = edge_inc;
        if (settled) begin
          // An edge on the final timeout cycle still counts as settled.
          state_d = GATE_ON;
        end else if (cyc_cnt_q == CYC_LAST) begin
          err_set = 1'b1;
          state_d = GATE_ON;
        end else begin
          cyc_cnt_d = cyc_cnt_q + 1'b1;
        end
      end
      GATE_ON: begin
        if (gate_cnt_q == GATE_LAST) begin
          gate_cnt_d = '0;
          state_d    = ACK;
        end else begin
          gate_cnt_d = gate_cnt_q + 1'b1;
        end
      end
      ACK: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State, counters and registered outputs; reset aborts any sequence.
  always_ff @(posedge clk_in) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      gate_cnt_q <= '0;
      cyc_cnt_q  <= '0;
      edge_cnt_q <= '0;
      fes_q      <= 1'b0;
      epis_q     <= 1'b0;
      hold_q     <= 1'b0;
      busy_q     <= 1'b0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      gate_cnt_q <= gate_cnt_d;
      cyc_cnt_q  <= cyc_cnt_d;
      edge_cnt_q <= edge_cnt_d;
      // Outputs decoded from the next state so they leave the flops glitch-free.
      hold_q     <= gating(state_d);
      busy_q     <= gating(state_d);
      ack_q      <= (state_d == ACK);
      if (sel_load) begin
        fes_q  <= fes_cap_q;
        epis_q <= epis_cap_q;
      end
      if (err_clr) begin
        err_q <= 1'b0;
      end else if (err_set) begin
        err_q <= 1'b1;
      end
    end
  end

  assign eth_rcc_fes    = fes_q;
  assign eth_rcc_epis_2 = epis_q;
  assign clk_gate_hold  = hold_q;
  assign mac.busy       = busy_q;
  assign mac.mac_ack    = ack_q;
  assign mac.err        = err_q;

endmodule

// File: tb/tb_rcc_eth_clk_sel_seq.sv
// Testbench for the ETH kernel clock select sequencer: table of directed
// requests, hand-written corner sequences, and randomized requests checked
// against a transaction-level model of the sequence timing.
module tb_rcc_eth_clk_sel_seq;

  localparam int G     = 4;
  localparam int ME    = 3;
  localparam int TO    = 1024;
  localparam int NEVER = 32'h7FFF_FFFF;

  logic clk_in;
  logic rst_n;
  logic rx_clk_tog;
  logic eth_rcc_fes;
  logic eth_rcc_epis_2;
  logic clk_gate_hold;

  rcc_eth_clk_sel_seq_if mif ();

  rcc_eth_clk_sel_seq #(
    .GATE_CYC  (G),
    .MIN_EDGES (ME),
    .TIMEOUT   (TO)
  ) dut (
    .clk_in         (clk_in),
    .rst_n          (rst_n),
    .mac            (mif),
    .rx_clk_tog     (rx_clk_tog),
    .eth_rcc_fes    (eth_rcc_fes),
    .eth_rcc_epis_2 (eth_rcc_epis_2),
    .clk_gate_hold  (clk_gate_hold)
  );

  initial begin
    clk_in = 1'b0;
    forever #5 clk_in = ~clk_in;
  end

  int n_pass = 0;
  int n_tot  = 0;
  int cyc    = 0;

  // RX toggle source: periodic when tog_per > 0, else transitions at tog_t*.
  int tog_per = 2;
  int tog_ph  = 0;
  int tog_t1  = NEVER;
  int tog_t2  = NEVER;
  int tog_t3  = NEVER;

  // Model of the architectural state seen by the MAC.
  bit m_fes  = 1'b0;
  bit m_epis = 1'b0;
  bit m_err  = 1'b0;

  typedef struct {
    bit fes;
    bit epis;
    int per;
    int r1;
    int r2;
    int r3;
    bit wig;
    bit gate;
    bit x_fes;
    bit x_epis;
    bit x_err;
  } vec_t;

  vec_t vt[7];

  function automatic logic tog_fn(input int k);
    if (tog_per > 0) return (((k + tog_ph) / tog_per) % 2) != 0;
    return (k >= tog_t1) ^ (k >= tog_t2) ^ (k >= tog_t3);
  endfunction

  task automatic chk(input string name, input int act, input int exp);
    n_tot++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk_in);
    #1;
    cyc++;
    rx_clk_tog = tog_fn(cyc);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Settle length: the switch settles on the first SETTLE cycle whose
  // RX sample makes the running change count reach ME; after TO cycles
  // without that the sequence gives up with an error.
  task automatic settle_model(input int s, output int len, output bit terr);
    int cnt;
    cnt  = 0;
    len  = TO;
    terr = 1'b1;
    for (int j = 1; j <= TO; j++) begin
      int k;
      k = s + G + j - 1;
      if (tog_fn(k) != tog_fn(k - 1)) cnt++;
      if (cnt >= ME) begin
        len  = j;
        terr = 1'b0;
        break;
      end
    end
  endtask

  // One MAC request; per = 0 selects explicit transitions at offsets r1..r3
  // from the select update (negative offset = no transition).
  task automatic do_req(input bit f, input bit e, input int per,
                        input int r1, input int r2, input int r3,
                        input bit wig, output bit gated);
    int  s, slen, exp_ack, ack_edge, acks, hold_n, busy_n, sel_edge, viol;
    bit  terr, noop, hold_prev, f_prev, e_prev;
    s       = cyc + 1;
    tog_per = per;
    tog_ph  = $urandom_range(0, 15);
    tog_t1  = (r1 >= 0) ? s + G + r1 : NEVER;
    tog_t2  = (r2 >= 0) ? s + G + r2 : NEVER;
    tog_t3  = (r3 >= 0) ? s + G + r3 : NEVER;
    rx_clk_tog = tog_fn(cyc);
    noop = (f == m_fes) && (e == m_epis);
    if (noop) begin
      slen    = 0;
      terr    = 1'b0;
      exp_ack = s;
    end else begin
      settle_model(s, slen, terr);
      exp_ack = s + 2 * G + slen;
    end
    mif.mac_req  = 1'b1;
    mif.mac_fes  = f;
    mif.mac_epis = e;
    ack_edge  = -1;
    acks      = 0;
    hold_n    = 0;
    busy_n    = 0;
    sel_edge  = -1;
    viol      = 0;
    hold_prev = clk_gate_hold;
    f_prev    = eth_rcc_fes;
    e_prev    = eth_rcc_epis_2;
    for (int i = 0; i < 2 * G + TO + 16; i++) begin
      tick();
      if (mif.mac_ack) begin
        acks++;
        if (ack_edge < 0) ack_edge = cyc;
        mif.mac_req = 1'b0;
      end
      if (clk_gate_hold) hold_n++;
      if (mif.busy) busy_n++;
      if (eth_rcc_fes != f_prev || eth_rcc_epis_2 != e_prev) begin
        if (sel_edge < 0) sel_edge = cyc;
        if (!clk_gate_hold || !hold_prev) viol++;
      end
      hold_prev = clk_gate_hold;
      f_prev    = eth_rcc_fes;
      e_prev    = eth_rcc_epis_2;
      if (wig && mif.busy) begin
        mif.mac_fes  = 1'($urandom_range(0, 1));
        mif.mac_epis = 1'($urandom_range(0, 1));
      end
      if (ack_edge >= 0 && cyc >= ack_edge + 3) break;
    end
    mif.mac_req = 1'b0;
    chk("ack_cycle", ack_edge, exp_ack);
    chk("ack_count", acks, 1);
    chk("hold_cycles", hold_n, noop ? 0 : 2 * G + slen);
    chk("busy_cycles", busy_n, noop ? 0 : 2 * G + slen);
    chk("select_update_cycle", sel_edge, noop ? -1 : s + G);
    chk("select_change_ungated", viol, 0);
    chk("final_fes", eth_rcc_fes, f);
    chk("final_epis", eth_rcc_epis_2, e);
    chk("final_err", mif.err, terr);
    m_fes  = f;
    m_epis = e;
    m_err  = terr;
    gated  = (hold_n > 0);
  endtask

  initial begin
    bit gated;
    int acks;

    vt[0] = '{1'b0, 1'b0, 2, -1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    vt[1] = '{1'b1, 1'b0, 2, -1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
    vt[2] = '{1'b1, 1'b0, 3, -1, -1, -1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    vt[3] = '{1'b1, 1'b1, 1, -1, -1, -1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0};
    vt[4] = '{1'b0, 1'b1, 0, -1, -1, -1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    vt[5] = '{1'b0, 1'b1, 2, -1, -1, -1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    vt[6] = '{1'b0, 1'b0, 5, -1, -1, -1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};

    rst_n        = 1'b0;
    mif.mac_req  = 1'b0;
    mif.mac_fes  = 1'b0;
    mif.mac_epis = 1'b0;
    rx_clk_tog   = 1'b0;

    // Reset state
    idle(3);
    chk("rst_fes", eth_rcc_fes, 0);
    chk("rst_epis", eth_rcc_epis_2, 0);
    chk("rst_hold", clk_gate_hold, 0);
    chk("rst_busy", mif.busy, 0);
    chk("rst_ack", mif.mac_ack, 0);
    chk("rst_err", mif.err, 0);
    rst_n = 1'b1;
    idle(2);
    chk("post_rst_hold", clk_gate_hold, 0);
    chk("post_rst_busy", mif.busy, 0);
    chk("post_rst_ack", mif.mac_ack, 0);

    // Directed table
    for (int i = 0; i < 7; i++) begin
      do_req(vt[i].fes, vt[i].epis, vt[i].per, vt[i].r1, vt[i].r2, vt[i].r3,
             vt[i].wig, gated);
      chk($sformatf("vec%0d_gated", i), gated, vt[i].gate);
      chk($sformatf("vec%0d_fes", i), eth_rcc_fes, vt[i].x_fes);
      chk($sformatf("vec%0d_epis", i), eth_rcc_epis_2, vt[i].x_epis);
      chk($sformatf("vec%0d_err", i), mif.err, vt[i].x_err);
      idle(2);
    end

    // Third edge lands exactly on the last SETTLE cycle: settled, no error
    do_req(1'b1, 1'b1, 0, 5, 10, TO - 1, 1'b0, gated);
    chk("edge_on_timeout_cycle_err", mif.err, 0);
    // Third edge one cycle too late: timeout, selects kept, error sticky
    do_req(1'b0, 1'b1, 0, 5, 10, TO, 1'b0, gated);
    chk("late_edge_err", mif.err, 1);
    idle(6);
    chk("err_sticky", mif.err, 1);
    chk("timeout_keeps_epis", eth_rcc_epis_2, 1);
    do_req(1'b1, 1'b1, 2, -1, -1, -1, 1'b0, gated);
    chk("err_cleared_by_req", mif.err, 0);

    // Reset during SETTLE aborts without ack
    tog_per = 0;
    tog_t1  = NEVER;
    tog_t2  = NEVER;
    tog_t3  = NEVER;
    rx_clk_tog   = tog_fn(cyc);
    mif.mac_fes  = ~m_fes;
    mif.mac_epis = m_epis;
    mif.mac_req  = 1'b1;
    idle(G + 6);
    chk("settle_hold_before_reset", clk_gate_hold, 1);
    rst_n       = 1'b0;
    mif.mac_req = 1'b0;
    tick();
    chk("abort_hold", clk_gate_hold, 0);
    chk("abort_fes", eth_rcc_fes, 0);
    chk("abort_epis", eth_rcc_epis_2, 0);
    chk("abort_busy", mif.busy, 0);
    chk("abort_ack", mif.mac_ack, 0);
    rst_n = 1'b1;
    acks  = 0;
    for (int i = 0; i < 12; i++) begin
      tick();
      if (mif.mac_ack) acks++;
    end
    chk("abort_no_ack", acks, 0);
    m_fes  = 1'b0;
    m_epis = 1'b0;
    m_err  = 1'b0;

    // Randomized requests against the model
    for (int n = 0; n < 40; n++) begin
      bit rf, re, rw;
      int rp;
      rf = 1'($urandom_range(0, 1));
      re = 1'($urandom_range(0, 1));
      rw = 1'($urandom_range(0, 1));
      rp = ($urandom_range(0, 11) == 0) ? 0 : int'($urandom_range(1, 8));
      do_req(rf, re, rp, -1, -1, -1, rw, gated);
      idle(int'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
